// File: rtl/jg3_mon_pkg.sv
// Shared types and constants for the jg3 event monitor.
// Holds the hold/alarm FSM state type and the width of the internal hold counter.
package jg3_mon_pkg;

    // Width of the internal consecutive-high counter used by the hold FSM
    localparam int HOLD_CNT_W = 8;

    // Hold/alarm FSM states; encoding 2'd3 is unused and recovers to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ALARM = 2'd2
    } hold_state_t;

endpackage

// File: rtl/jg3_sync_edge.sv
// Multi-flop synchroniser with rising-edge detection.
// q_sync is the last synchroniser flop. rise is high for one cycle when q_sync
// goes from 0 to 1, compared against q_sync from the previous cycle.
module jg3_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw input through the synchroniser chain and remember the last synced value
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = q_sync & ~prev_q;

endmodule

// File: rtl/jg3_event_monitor.sv
// Event monitor for the X/Y outputs of the 3-bit decoder.
// Synchronises X and Y, counts their rising edges in saturating counters, and
// raises x_alarm once synced X has been high for HOLD_CYCLES consecutive cycles.
// Optional feature macro: JG3_MON_COMBO_EN adds combo_count, a saturating count
// of cycles in which synced X and Y are both high.
module jg3_event_monitor
    import jg3_mon_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_in,
    input  logic             y_in,
    input  logic             clr,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count,
    output logic             x_alarm,
    output logic [1:0]       hold_state
`ifdef JG3_MON_COMBO_EN
    ,
    output logic [CNT_W-1:0] combo_count
`endif
);

    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_ONE  = HOLD_CNT_W'(1);

    logic x_sync, x_rise;
    logic y_sync, y_rise;

    logic [CNT_W-1:0]      x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0]      y_cnt_q, y_cnt_d;
    hold_state_t           state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                  x_alarm_q;

    jg3_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_x (
        .clk    (clk),
        .rst    (rst),
        .d      (x_in),
        .q_sync (x_sync),
        .rise   (x_rise)
    );

    jg3_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_y (
        .clk    (clk),
        .rst    (rst),
        .d      (y_in),
        .q_sync (y_sync),
        .rise   (y_rise)
    );

    // Edge counters: clear wins over a same-cycle rise, and counting stops at all-ones
    always_comb begin
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        if (clr) begin
            x_cnt_d = '0;
            y_cnt_d = '0;
        end else begin
            if (x_rise && (x_cnt_q != CNT_MAX)) begin
                x_cnt_d = x_cnt_q + 1'b1;
            end
            if (y_rise && (y_cnt_q != CNT_MAX)) begin
                y_cnt_d = y_cnt_q + 1'b1;
            end
        end
    end

    // Hold FSM next state: track how long synced X has stayed high
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (x_sync) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_ONE;
                end
            end
            ST_HOLD: begin
                if (!x_sync) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_ALARM;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            ST_ALARM: begin
                if (!x_sync) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Register counters, FSM state and the alarm flag (alarm follows the state being entered)
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            x_alarm_q  <= 1'b0;
        end else begin
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            x_alarm_q  <= (state_d == ST_ALARM);
        end
    end

    assign x_count    = x_cnt_q;
    assign y_count    = y_cnt_q;
    assign x_alarm    = x_alarm_q;
    assign hold_state = state_q;

`ifdef JG3_MON_COMBO_EN
    logic [CNT_W-1:0] combo_cnt_q, combo_cnt_d;

    // Combo counter next value: count cycles with both synced inputs high, saturating
    always_comb begin
        combo_cnt_d = combo_cnt_q;
        if (clr) begin
            combo_cnt_d = '0;
        end else if (x_sync && y_sync && (combo_cnt_q != CNT_MAX)) begin
            combo_cnt_d = combo_cnt_q + 1'b1;
        end
    end

    // Register the combo counter
    always_ff @(posedge clk) begin
        if (rst) begin
            combo_cnt_q <= '0;
        end else begin
            combo_cnt_q <= combo_cnt_d;
        end
    end

    assign combo_count = combo_cnt_q;
`else
    // Synced Y level only feeds the combo counter, which is absent in this build
    logic unused_y_sync;
    assign unused_y_sync = y_sync;
`endif

endmodule

// File: tb/tb_jg3_event_monitor.sv
// Self-checking bench for jg3_event_monitor.
// A sample-history reference model predicts every output: synced values are
// looked up from the list of input samples taken since reset, and the alarm
// state is derived from the length of the current run of synced-high X.
// Honours JG3_MON_COMBO_EN when the design is built with it.
module tb_jg3_event_monitor;

    localparam int CNT_W       = 3;
    localparam int HOLD_CYCLES = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_MAXI    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             x_in = 1'b0;
    logic             y_in = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] x_count;
    logic [CNT_W-1:0] y_count;
    logic             x_alarm;
    logic [1:0]       hold_state;
`ifdef JG3_MON_COMBO_EN
    logic [CNT_W-1:0] combo_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit xHist[$];
    bit yHist[$];
    int mX, mY, mCombo, mRun;

    jg3_event_monitor #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_in       (x_in),
        .y_in       (y_in),
        .clr        (clr),
        .x_count    (x_count),
        .y_count    (y_count),
        .x_alarm    (x_alarm),
        .hold_state (hold_state)
`ifdef JG3_MON_COMBO_EN
        ,
        .combo_count(combo_count)
`endif
    );

    always #5 clk = ~clk;

    // Synced value visible after k non-reset edges: the sample taken SYNC_STAGES-1 edges earlier
    function automatic bit xsAt(int k);
        int idx = k - SYNC_STAGES;
        if (idx >= 0 && idx < xHist.size()) return xHist[idx];
        return 1'b0;
    endfunction

    function automatic bit ysAt(int k);
        int idx = k - SYNC_STAGES;
        if (idx >= 0 && idx < yHist.size()) return yHist[idx];
        return 1'b0;
    endfunction

    function automatic int expAlarm();
        return (mRun >= HOLD_CYCLES) ? 1 : 0;
    endfunction

    function automatic int expState();
        if (mRun == 0) return 0;
        if (mRun < HOLD_CYCLES) return 1;
        return 2;
    endfunction

    // Advance the model by one clock edge with the inputs sampled at that edge
    task automatic modelEdge(input bit x, input bit y, input bit c, input bit r);
        int  len;
        bit  xs, xp, ys, yp;
        if (r) begin
            xHist.delete();
            yHist.delete();
            mX = 0; mY = 0; mCombo = 0; mRun = 0;
        end else begin
            len = xHist.size();
            xs = xsAt(len);
            xp = xsAt(len - 1);
            ys = ysAt(len);
            yp = ysAt(len - 1);
            if (c) begin
                mX = 0; mY = 0; mCombo = 0;
            end else begin
                if (xs && !xp && mX < CNT_MAXI) mX++;
                if (ys && !yp && mY < CNT_MAXI) mY++;
                if (xs && ys && mCombo < CNT_MAXI) mCombo++;
            end
            if (xs) mRun = (mRun < 255) ? mRun + 1 : mRun;
            else    mRun = 0;
            xHist.push_back(x);
            yHist.push_back(y);
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, then settle before sampling
    task automatic applyStimulus(input bit x, input bit y, input bit c, input bit r);
        @(negedge clk);
        x_in = x; y_in = y; clr = c; rst = r;
        @(posedge clk);
        modelEdge(x, y, c, r);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 1, 0, 1);
        checks++; if (x_count !== '0) begin errors++; $display("[TB] FAIL reset_x_count: got %0d expected 0", x_count); end
        checks++; if (y_count !== '0) begin errors++; $display("[TB] FAIL reset_y_count: got %0d expected 0", y_count); end
        checks++; if (x_alarm !== 1'b0) begin errors++; $display("[TB] FAIL reset_x_alarm: got %0b expected 0", x_alarm); end
        checks++; if (hold_state !== 2'd0) begin errors++; $display("[TB] FAIL reset_hold_state: got %0d expected 0", hold_state); end
    endtask

    task automatic test_counting();
        applyStimulus(0, 0, 0, 1);
        // First pulse with explicit latency checks
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checks++; if (x_count !== 3'd0) begin errors++; $display("[TB] FAIL count_latency_edge2: got %0d expected 0", x_count); end
        applyStimulus(0, 0, 0, 0);
        checks++; if (x_count !== 3'd1) begin errors++; $display("[TB] FAIL count_latency_edge3: got %0d expected 1", x_count); end
        applyStimulus(0, 0, 0, 0);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus(k < 2, 0, 0, 0);
                checks++;
                if (x_count !== CNT_W'(mX)) begin
                    errors++; $display("[TB] FAIL count_track: got %0d expected %0d", x_count, mX);
                end
            end
        end
        for (int k = 0; k < SYNC_STAGES + 1; k++) applyStimulus(0, 0, 0, 0);
        checks++; if (x_count !== 3'd5) begin errors++; $display("[TB] FAIL count_x_total: got %0d expected 5", x_count); end
        checks++; if (y_count !== 3'd0) begin errors++; $display("[TB] FAIL count_y_total: got %0d expected 0", y_count); end
    endtask

    task automatic test_saturation();
        applyStimulus(0, 0, 0, 1);
        for (int p = 0; p < 9; p++) begin
            for (int k = 0; k < 4; k++) applyStimulus(0, k < 2, 0, 0);
        end
        for (int k = 0; k < SYNC_STAGES + 1; k++) applyStimulus(0, 0, 0, 0);
        checks++; if (y_count !== 3'd7) begin errors++; $display("[TB] FAIL sat_y_count: got %0d expected 7", y_count); end
        applyStimulus(0, 0, 1, 0);
        checks++; if (y_count !== 3'd0) begin errors++; $display("[TB] FAIL sat_clr: got %0d expected 0", y_count); end
        // Rise of synced Y lands at the third edge; clear it in that same cycle
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        checks++; if (y_count !== 3'd0) begin errors++; $display("[TB] FAIL sat_clr_with_rise: got %0d expected 0", y_count); end
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
        checks++; if (y_count !== 3'd0) begin errors++; $display("[TB] FAIL sat_rise_dropped: got %0d expected 0", y_count); end
    endtask

    task automatic test_alarm();
        bit cleared;
        applyStimulus(0, 0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(k < 3, 0, 0, 0);
            checks++;
            if (x_alarm !== 1'b0) begin errors++; $display("[TB] FAIL alarm_short_run: got %0b expected 0", x_alarm); end
        end
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1, 0, 0, 0);
            checks++;
            if (x_alarm !== 1'(k >= 6)) begin
                errors++; $display("[TB] FAIL alarm_threshold_edge%0d: got %0b expected %0b", k, x_alarm, k >= 6);
            end
            checks++;
            if (hold_state !== 2'(expState())) begin
                errors++; $display("[TB] FAIL alarm_state: got %0d expected %0d", hold_state, expState());
            end
        end
        cleared = 1'b0;
        for (int k = 0; k < SYNC_STAGES + 1; k++) begin
            applyStimulus(0, 0, 0, 0);
            if (x_alarm === 1'b0) cleared = 1'b1;
        end
        checks++; if (!cleared) begin errors++; $display("[TB] FAIL alarm_release: got %0b expected 0 within %0d cycles", x_alarm, SYNC_STAGES + 1); end
        checks++; if (hold_state !== 2'd0) begin errors++; $display("[TB] FAIL alarm_release_state: got %0d expected 0", hold_state); end
    endtask

    task automatic test_reset_mid_alarm();
        applyStimulus(0, 0, 0, 1);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) applyStimulus(k < 2, k < 2, 0, 0);
        end
        for (int k = 0; k < 8; k++) applyStimulus(1, 0, 0, 0);
        checks++; if (x_alarm !== 1'b1) begin errors++; $display("[TB] FAIL mid_alarm_pre: got %0b expected 1", x_alarm); end
        checks++; if (x_count !== 3'd3) begin errors++; $display("[TB] FAIL mid_alarm_x_count: got %0d expected 3", x_count); end
        checks++; if (y_count !== 3'd2) begin errors++; $display("[TB] FAIL mid_alarm_y_count: got %0d expected 2", y_count); end
        applyStimulus(1, 0, 0, 1);
        checks++; if (x_alarm !== 1'b0) begin errors++; $display("[TB] FAIL mid_alarm_rst_alarm: got %0b expected 0", x_alarm); end
        checks++; if (hold_state !== 2'd0) begin errors++; $display("[TB] FAIL mid_alarm_rst_state: got %0d expected 0", hold_state); end
        checks++; if (x_count !== 3'd0 || y_count !== 3'd0) begin errors++; $display("[TB] FAIL mid_alarm_rst_counts: got %0d/%0d expected 0/0", x_count, y_count); end
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 0, 0, 0);
            checks++;
            if (hold_state !== 2'((k < 3) ? 0 : (k < 6) ? 1 : 2)) begin
                errors++; $display("[TB] FAIL mid_alarm_rehold_edge%0d: got %0d", k, hold_state);
            end
        end
        checks++; if (x_alarm !== 1'b1) begin errors++; $display("[TB] FAIL mid_alarm_realarm: got %0b expected 1", x_alarm); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checks++; if (x_count !== 3'd1 || y_count !== 3'd1) begin errors++; $display("[TB] FAIL simultaneous_rise: got %0d/%0d expected 1/1", x_count, y_count); end
    endtask

`ifdef JG3_MON_COMBO_EN
    task automatic test_combo();
        applyStimulus(0, 0, 0, 1);
        for (int k = 0; k < 6; k++) applyStimulus(1, 1, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0);
        checks++; if (combo_count !== 3'd6) begin errors++; $display("[TB] FAIL combo_count: got %0d expected 6", combo_count); end
    endtask
`endif

    task automatic test_random();
        bit x, y, c, r;
        applyStimulus(0, 0, 0, 1);
        x = 0; y = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) x = ~x;
            if ($urandom_range(0, 2) == 0) y = ~y;
            c = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 99) == 0);
            applyStimulus(x, y, c, r);
            checks++; if (x_count !== CNT_W'(mX)) begin errors++; $display("[TB] FAIL rand_x_count cyc%0d: got %0d expected %0d", n, x_count, mX); end
            checks++; if (y_count !== CNT_W'(mY)) begin errors++; $display("[TB] FAIL rand_y_count cyc%0d: got %0d expected %0d", n, y_count, mY); end
            checks++; if (x_alarm !== 1'(expAlarm())) begin errors++; $display("[TB] FAIL rand_x_alarm cyc%0d: got %0b expected %0d", n, x_alarm, expAlarm()); end
            checks++; if (hold_state !== 2'(expState())) begin errors++; $display("[TB] FAIL rand_hold_state cyc%0d: got %0d expected %0d", n, hold_state, expState()); end
`ifdef JG3_MON_COMBO_EN
            checks++; if (combo_count !== CNT_W'(mCombo)) begin errors++; $display("[TB] FAIL rand_combo cyc%0d: got %0d expected %0d", n, combo_count, mCombo); end
`endif
        end
    endtask

    initial begin
        $display("[TB] starting jg3_event_monitor bench");
        test_reset();
        test_counting();
        test_saturation();
        test_alarm();
        test_reset_mid_alarm();
        test_back_to_back();
`ifdef JG3_MON_COMBO_EN
        test_combo();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
